// File: rtl/pooling_ctrl.sv
// Pooling datapath sequencer: walks one feature map (stride / column / row counters)
// and emits the delayed per-cycle control word for the shift/pop/row-FIFO/pool stages.
module pooling_ctrl #(
    parameter int NUM_PE     = 4,
    parameter int DIM_WIDTH  = 10,
    parameter int CTRL_WIDTH = 6,
    parameter int CFG_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIM_WIDTH-1:0]  cfg_input_width,
    input  logic [DIM_WIDTH-1:0]  cfg_input_height,
    input  logic                  cfg_kernel_size,
    input  logic [1:0]            cfg_stride,
    input  logic                  ready,
    output logic [CTRL_WIDTH-1:0] ctrl,
    output logic [CFG_WIDTH-1:0]  cfg,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            state_dbg
);

    localparam int PE_SHIFT = (NUM_PE > 1) ? $clog2(NUM_PE) : 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state;
    logic [DIM_WIDTH-1:0] width_q;
    logic [DIM_WIDTH-1:0] height_q;
    logic                 kernel3_q;
    logic [1:0]           stride_q;
    logic [1:0]           stride_count;
    logic [DIM_WIDTH-1:0] iw_count;
    logic [DIM_WIDTH-1:0] ih_count;
    logic [DIM_WIDTH-1:0] ih_count_d;
    logic [2:0]           drain_count;
    logic                 err_pend;

    logic                 run;
    logic                 cfg_illegal;
    logic                 stride_inc;
    logic                 iw_inc;
    logic                 ih_inc;
    logic                 ih_clear;
    logic                 kh_count;
    logic                 stride_last;
    logic                 iw_last;
    logic [DIM_WIDTH-1:0] iw_max;
    logic [DIM_WIDTH-1:0] height_last;
    logic [DIM_WIDTH-1:0] min_rows;

    logic                 pop_raw, shift_raw, raw_fifo, push_raw, rpop_raw;
    logic                 mux_raw, pv_raw, ks_raw;
    logic                 pop_d1, pop_d2;
    logic [1:0]           shift_d;
    logic [2:0]           push_d, rpop_d;
    logic [3:0]           mux_d, pv_d, ks_d;

    // ready means the datapath holds an input word this cycle; a word is consumed
    // only when stride_count==0, and mid-stride steps proceed regardless of ready.
    always_comb begin
        run         = (state == RUN);
        iw_max      = (width_q >> PE_SHIFT) - DIM_WIDTH'(1);
        height_last = height_q - DIM_WIDTH'(1);
        stride_last = (stride_count == (stride_q - 2'd1));
        iw_last     = (iw_count == iw_max);
        kh_count    = ih_count[0];
        stride_inc  = run && ((stride_count != 2'd0) || ready);
        iw_inc      = stride_inc && stride_last;
        ih_inc      = iw_inc && iw_last;
        ih_clear    = ih_inc && (ih_count == height_last);

        min_rows    = cfg_kernel_size ? DIM_WIDTH'(3) : DIM_WIDTH'(2);
        cfg_illegal = (cfg_input_width < DIM_WIDTH'(NUM_PE)) ||
                      ((cfg_input_width & DIM_WIDTH'(NUM_PE - 1)) != '0) ||
                      (cfg_input_height < min_rows) ||
                      (cfg_stride == 2'd0);

        pop_raw   = run && (stride_count == 2'd0) && ready;
        shift_raw = stride_inc && !pop_d1;
        raw_fifo  = run && (shift_d[0] || (pop_d2 && ready)) && !(!kernel3_q && kh_count);
        push_raw  = raw_fifo && (ih_count_d != height_last);
        rpop_raw  = raw_fifo && (ih_count != '0);
        mux_raw   = run && !kh_count;
        pv_raw    = run && ((ih_count == height_last) ||
                            (kernel3_q ? (!kh_count && (ih_count != '0)) : kh_count));
        ks_raw    = run && kernel3_q && !(iw_last && stride_last);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            width_q      <= '0;
            height_q     <= '0;
            kernel3_q    <= 1'b0;
            stride_q     <= 2'd0;
            stride_count <= 2'd0;
            iw_count     <= '0;
            ih_count     <= '0;
            drain_count  <= 3'd0;
            err_pend     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            done     <= err_pend || ((state == DRAIN) && (drain_count == 3'd3));
            err_pend <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_illegal) begin
                            err      <= 1'b1;
                            err_pend <= 1'b1;
                        end else begin
                            err          <= 1'b0;
                            width_q      <= cfg_input_width;
                            height_q     <= cfg_input_height;
                            kernel3_q    <= cfg_kernel_size;
                            stride_q     <= cfg_stride;
                            stride_count <= 2'd0;
                            iw_count     <= '0;
                            ih_count     <= '0;
                            busy         <= 1'b1;
                            state        <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (stride_inc) begin
                        stride_count <= stride_last ? 2'd0 : stride_count + 2'd1;
                        if (iw_inc) iw_count <= iw_last ? '0 : iw_count + DIM_WIDTH'(1);
                        if (ih_inc) ih_count <= ih_clear ? '0 : ih_count + DIM_WIDTH'(1);
                        if (ih_clear) begin
                            drain_count <= 3'd0;
                            state       <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_count == 3'd4) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        drain_count <= drain_count + 3'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Delay lines run every cycle so controls issued in the last RUN cycles drain out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pop_d1     <= 1'b0;
            pop_d2     <= 1'b0;
            shift_d    <= '0;
            push_d     <= '0;
            rpop_d     <= '0;
            mux_d      <= '0;
            pv_d       <= '0;
            ks_d       <= '0;
            ih_count_d <= '0;
        end else begin
            pop_d1     <= pop_raw;
            pop_d2     <= pop_d1;
            shift_d    <= {shift_d[0], shift_raw};
            push_d     <= {push_d[1:0], push_raw};
            rpop_d     <= {rpop_d[1:0], rpop_raw};
            mux_d      <= {mux_d[2:0], mux_raw};
            pv_d       <= {pv_d[2:0], pv_raw};
            ks_d       <= {ks_d[2:0], ks_raw};
            ih_count_d <= ih_count;
        end
    end

    assign ctrl      = CTRL_WIDTH'({pv_d[3], mux_d[3], rpop_d[2], push_d[2], pop_d1, shift_d[1]});
    assign cfg       = CFG_WIDTH'({ks_d[3], stride_q});
    assign state_dbg = state;

endmodule

// File: tb/tb_pooling_ctrl.sv
// Bench for pooling_ctrl: frame-position model (counters derived arithmetically from
// the number of stride steps taken) compared against the DUT every cycle.
module tb_pooling_ctrl;

  localparam int NUM_PE = 4;
  localparam int DIM_WIDTH = 10;
  localparam int CTRL_WIDTH = 6;
  localparam int CFG_WIDTH = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [DIM_WIDTH-1:0] cfg_input_width = '0;
  logic [DIM_WIDTH-1:0] cfg_input_height = '0;
  logic cfg_kernel_size = 1'b0;
  logic [1:0] cfg_stride = 2'd0;
  logic ready = 1'b0;
  logic [CTRL_WIDTH-1:0] ctrl;
  logic [CFG_WIDTH-1:0] cfg;
  logic busy, done, err;
  logic [1:0] state_dbg;

  int n_cmp = 0;
  int n_fail = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pooling_ctrl #(
    .NUM_PE(NUM_PE), .DIM_WIDTH(DIM_WIDTH), .CTRL_WIDTH(CTRL_WIDTH), .CFG_WIDTH(CFG_WIDTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_input_width(cfg_input_width), .cfg_input_height(cfg_input_height),
    .cfg_kernel_size(cfg_kernel_size), .cfg_stride(cfg_stride), .ready(ready),
    .ctrl(ctrl), .cfg(cfg), .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_state, m_p, m_drain, m_w, m_h, m_s;
  bit m_k3, m_err, m_errpend;
  bit h_pop1, h_pop2, h_shift1;
  int h_ih1;
  bit q_shift[$], q_push[$], q_rpop[$], q_mux[$], q_pv[$], q_ks[$];
  logic [5:0] e_ctrl;
  logic [2:0] e_cfg;
  logic e_busy, e_done, e_err;

  task automatic model_reset();
    m_state = 0; m_p = 0; m_drain = 0; m_w = 0; m_h = 0; m_s = 0;
    m_k3 = 0; m_err = 0; m_errpend = 0;
    h_pop1 = 0; h_pop2 = 0; h_shift1 = 0; h_ih1 = 0;
    q_shift.delete(); q_push.delete(); q_rpop.delete();
    q_mux.delete(); q_pv.delete(); q_ks.delete();
    q_shift.push_back(1'b0);
    repeat (2) begin q_push.push_back(1'b0); q_rpop.push_back(1'b0); end
    repeat (3) begin q_mux.push_back(1'b0); q_pv.push_back(1'b0); q_ks.push_back(1'b0); end
    e_ctrl = '0; e_cfg = '0; e_busy = 0; e_done = 0; e_err = 0;
  endtask

  // Predicts the outputs that follow the next rising edge from the inputs now applied.
  task automatic model_step();
    int words, sc, iw, ih, kh, min_h;
    bit run, stride_inc, pop_raw, shift_raw, raw_fifo, push_raw, rpop_raw, mux_raw, pv_raw, ks_raw;
    bit s_shift, s_push, s_rpop, s_mux, s_pv, s_ks, done_next, illegal;
    run = (m_state == 1);
    words = 1; sc = 0; iw = 0; ih = 0;
    if (run) begin
      words = m_w / NUM_PE;
      sc = m_p % m_s;
      iw = (m_p / m_s) % words;
      ih = m_p / (m_s * words);
    end
    kh = ih % 2;
    pop_raw    = run && sc == 0 && ready;
    stride_inc = run && (sc != 0 || ready);
    shift_raw  = stride_inc && !h_pop1;
    raw_fifo   = run && (h_shift1 || (h_pop2 && ready)) && !(!m_k3 && kh == 1);
    push_raw   = raw_fifo && h_ih1 != m_h - 1;
    rpop_raw   = raw_fifo && ih != 0;
    mux_raw    = run && kh == 0;
    pv_raw     = run && (ih == m_h - 1 || (m_k3 ? (kh == 0 && ih != 0) : kh == 1));
    ks_raw     = run && m_k3 && !(iw == words - 1 && sc == m_s - 1);

    h_pop2 = h_pop1; h_pop1 = pop_raw; h_shift1 = shift_raw; h_ih1 = ih;
    q_shift.push_back(shift_raw); s_shift = q_shift.pop_front();
    q_push.push_back(push_raw);   s_push  = q_push.pop_front();
    q_rpop.push_back(rpop_raw);   s_rpop  = q_rpop.pop_front();
    q_mux.push_back(mux_raw);     s_mux   = q_mux.pop_front();
    q_pv.push_back(pv_raw);       s_pv    = q_pv.pop_front();
    q_ks.push_back(ks_raw);       s_ks    = q_ks.pop_front();

    done_next = m_errpend || (m_state == 2 && m_drain == 3);
    m_errpend = 0;
    case (m_state)
      0: if (start) begin
        min_h = cfg_kernel_size ? 3 : 2;
        illegal = (int'(cfg_input_width) < NUM_PE) || (int'(cfg_input_width) % NUM_PE != 0) ||
                  (int'(cfg_input_height) < min_h) || (cfg_stride == 0);
        if (illegal) begin
          m_err = 1; m_errpend = 1;
        end else begin
          m_err = 0; m_w = int'(cfg_input_width); m_h = int'(cfg_input_height);
          m_k3 = cfg_kernel_size; m_s = int'(cfg_stride); m_p = 0; m_state = 1;
        end
      end
      1: if (stride_inc) begin
        if (m_p + 1 == m_s * words * m_h) begin
          m_p = 0; m_drain = 0; m_state = 2;
        end else begin
          m_p++;
        end
      end
      default: if (m_drain == 4) m_state = 0; else m_drain++;
    endcase

    e_ctrl = {s_pv, s_mux, s_rpop, s_push, pop_raw, s_shift};
    e_cfg  = {s_ks, 2'(m_s)};
    e_busy = (m_state != 0);
    e_done = done_next;
    e_err  = m_err;
  endtask

  // ---------------- compare process + frame monitors ----------------
  int f_pop, f_pv, f_push, f_rpop, f_done;

  always @(negedge clk) begin
    if (!reset) model_reset();
    check("ctrl", 32'(ctrl), 32'(e_ctrl));
    check("cfg", 32'(cfg), 32'(e_cfg));
    check("busy", 32'(busy), 32'(e_busy));
    check("done", 32'(done), 32'(e_done));
    check("err", 32'(err), 32'(e_err));
    if (ctrl[1]) f_pop++;
    if (ctrl[5]) f_pv++;
    if (ctrl[2]) f_push++;
    if (ctrl[3]) f_rpop++;
    if (done) f_done++;
    if (reset) model_step();
  end

  // ---------------- driver tasks ----------------
  int ready_mode = 0;

  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: ready = 1'b1;
        1: ready = ~ready;
        default: ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic clear_counts();
    f_pop = 0; f_pv = 0; f_push = 0; f_rpop = 0; f_done = 0;
  endtask

  task automatic do_start(input int w, input int h, input int k, input int s);
    @(posedge clk); #1;
    cfg_input_width = DIM_WIDTH'(w);
    cfg_input_height = DIM_WIDTH'(h);
    cfg_kernel_size = 1'(k);
    cfg_stride = 2'(s);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 2000) begin
      @(negedge clk);
      if (done) seen = 1;
      n++;
    end
    if (!seen) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, n);
    end
    @(negedge clk);
    check({name, "_busy_after"}, 32'(busy), 0);
    @(negedge clk);
  endtask

  task automatic run_frame(input string name, input int w, input int h, input int k, input int s);
    clear_counts();
    do_start(w, h, k, s);
    wait_done(name);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", 32'(ctrl), 0);
    check("rst_cfg", 32'(cfg), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    reset = 1'b1;

    // 8x4, 2x2, stride 2, ready held
    ready_mode = 0;
    run_frame("t1", 8, 4, 0, 2);
    check("t1_pops", f_pop, 8);
    check("t1_pool_valid", f_pv, 8);
    check("t1_push", f_push, 7);
    check("t1_rpop", f_rpop, 4);
    check("t1_done", f_done, 1);

    // 8x5, 3x3, stride 2
    run_frame("t2", 8, 5, 1, 2);
    check("t2_pops", f_pop, 10);
    check("t2_pool_valid", f_pv, 8);
    check("t2_push", f_push, 16);
    check("t2_rpop", f_rpop, 16);
    check("t2_done", f_done, 1);

    // ready toggling every cycle
    ready_mode = 1;
    run_frame("t3", 8, 4, 0, 2);
    check("t3_pops", f_pop, 8);
    check("t3_done", f_done, 1);
    ready_mode = 0;

    // illegal width
    clear_counts();
    do_start(6, 4, 0, 2);
    @(negedge clk);
    check("t4_err", 32'(err), 1);
    check("t4_done_early", 32'(done), 0);
    check("t4_busy", 32'(busy), 0);
    @(negedge clk);
    check("t4_done", 32'(done), 1);
    check("t4_ctrl", 32'(ctrl), 0);
    @(negedge clk);
    check("t4_done_once", 32'(done), 0);
    check("t4_err_held", 32'(err), 1);

    // asynchronous reset in row 2
    clear_counts();
    do_start(8, 4, 0, 2);
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("t5_ctrl_async", 32'(ctrl), 0);
    check("t5_busy_async", 32'(busy), 0);
    check("t5_state_async", 32'(state_dbg), 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_no_done", f_done, 0);
    run_frame("t5b", 8, 4, 0, 2);
    check("t5b_pops", f_pop, 8);
    check("t5b_done", f_done, 1);

    // start while busy is ignored
    clear_counts();
    do_start(8, 4, 0, 2);
    repeat (3) @(posedge clk);
    #1;
    cfg_input_width = DIM_WIDTH'(16); cfg_input_height = DIM_WIDTH'(6);
    cfg_kernel_size = 1'b1; cfg_stride = 2'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t6");
    check("t6_stride_kept", 32'(cfg[1:0]), 2);
    check("t6_pops", f_pop, 8);
    check("t6_done", f_done, 1);

    // randomized frames, legal and illegal
    ready_mode = 2;
    for (int i = 0; i < 14; i++) begin
      run_frame("rnd", NUM_PE * $urandom_range(1, 4), $urandom_range(2, 6),
                $urandom_range(0, 1), $urandom_range(0, 3));
      check("rnd_done", f_done, 1);
    end
    if ($urandom_range(0, 1) == 1) run_frame("rnd_odd", 5, 3, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
